arcade_input_mapper: RTL and testbench

- Parametrised input front-end for arcade cores: merges PS/2 keyboard state and HPS joysticks into per-player active-high controls.
- Sits between hps_io and the game core.
- Adds per-player mapping, display-rotation remap, opposite-direction (SOCD) cleaning and stretched coin pulses.
- Replaces per-core ad-hoc keyboard case statements.

---
 rtl/arcade_input_mapper.sv | 240 ++++++++++++++++++++++++
 tb/tb_arcade_input_mapper.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// Arcade input front-end: PS/2 key latches + HPS joysticks -> per-player controls with
// SOCD cleaning, rotation remap and stretched coin. Optional autofire: INPUT_AUTOFIRE_EN.

module arcade_player_ctl #(
    parameter int          BUTTONS    = 2,
    parameter logic [15:0] COIN_PULSE = 16'd50000
) (
    input  logic               clk_sys,
    input  logic               rst,
    input  logic [3:0]         dir_i,
    input  logic [BUTTONS-1:0] btn_i,
    input  logic               start_i,
    input  logic               coin_i,
    input  logic [1:0]         rotate_i,
    input  logic [BUTTONS-1:0] fire_gate_i,
    output logic [3:0]         dir_o,
    output logic [BUTTONS-1:0] btn_o,
    output logic               start_o,
    output logic               coin_o
);
    typedef enum logic [1:0] {C_IDLE, C_PULSE, C_WAIT} coin_st_e;

    coin_st_e           st_q, st_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               coin_q, coin_d, coin_prev_q;
    logic [3:0]         dir_q, dir_d, clean;
    logic [BUTTONS-1:0] btn_q;
    logic               start_q;

    // {U,D,L,R}: opposing pairs cancel before the rotation remap
    always_comb begin
        clean = dir_i;
        if (dir_i[3] && dir_i[2]) clean[3:2] = 2'b00;
        if (dir_i[1] && dir_i[0]) clean[1:0] = 2'b00;
        case (rotate_i)
            2'd1:    dir_d = {clean[1], clean[0], clean[2], clean[3]};
            2'd2:    dir_d = {clean[0], clean[1], clean[3], clean[2]};
            default: dir_d = clean;
        endcase
    end

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        coin_d = coin_q;
        case (st_q)
            C_IDLE: begin
                if (coin_i && !coin_prev_q) begin
                    st_d   = C_PULSE;
                    cnt_d  = COIN_PULSE;
                    coin_d = 1'b1;
                end
            end
            C_PULSE: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    coin_d = 1'b0;
                    st_d   = coin_i ? C_WAIT : C_IDLE;
                end
            end
            C_WAIT: begin
                if (!coin_i) st_d = C_IDLE;
            end
            default: st_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            st_q        <= C_IDLE;
            cnt_q       <= '0;
            coin_q      <= 1'b0;
            coin_prev_q <= 1'b0;
            dir_q       <= '0;
            btn_q       <= '0;
            start_q     <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            coin_q      <= coin_d;
            coin_prev_q <= coin_i;
            dir_q       <= dir_d;
            btn_q       <= btn_i & fire_gate_i;
            start_q     <= start_i;
        end
    end

    assign dir_o   = dir_q;
    assign btn_o   = btn_q;
    assign start_o = start_q;
    assign coin_o  = coin_q;
endmodule

module arcade_input_mapper #(
    parameter int          PLAYERS      = 2,
    parameter int          BUTTONS      = 2,
    parameter logic [15:0] COIN_PULSE   = 16'd50000,
    parameter logic [19:0] AUTOFIRE_DIV = 20'd400000
) (
    input  logic                         clk_sys,
    input  logic                         RESET,
    input  logic [10:0]                  ps2_key,
    input  logic [16*PLAYERS-1:0]        joy_in,
    input  logic [1:0]                   rotate,
    output logic [4*PLAYERS-1:0]         out_dir,
    output logic [BUTTONS*PLAYERS-1:0]   out_btn,
    output logic [PLAYERS-1:0]           out_start,
    output logic [PLAYERS-1:0]           out_coin,
    output logic                         out_test,
    input  logic [BUTTONS*PLAYERS-1:0]   autofire_en
);
    localparam int NK = 23;

    logic          armed_q, tog_q, test_q, key_ev;
    logic [8:0]    code;
    logic [NK-1:0] hit, kl_q, kl_d;
    logic [BUTTONS*PLAYERS-1:0] gate;

    assign code   = ps2_key[8:0];
    assign key_ev = armed_q && (ps2_key[10] != tog_q);

    // Latch slots: 0-3 P0 {R,L,D,U}, 4-7 P0 btn, 8-9 P0 start, 10 P0 coin,
    // 11-21 same layout for P1, 22 test. Arrows ignore the E0 prefix bit.
    always_comb begin
        hit = '0;
        case (code[7:0])
            8'h75:   hit[3] = 1'b1;
            8'h72:   hit[2] = 1'b1;
            8'h6B:   hit[1] = 1'b1;
            8'h74:   hit[0] = 1'b1;
            default: ;
        endcase
        case (code)
            9'h014: hit[4]  = 1'b1;
            9'h029: hit[5]  = 1'b1;
            9'h011: hit[6]  = 1'b1;
            9'h012: hit[7]  = 1'b1;
            9'h016: hit[8]  = 1'b1;
            9'h005: hit[9]  = 1'b1;
            9'h02E: hit[10] = 1'b1;
            9'h034: hit[11] = 1'b1;
            9'h023: hit[12] = 1'b1;
            9'h02B: hit[13] = 1'b1;
            9'h02D: hit[14] = 1'b1;
            9'h01C: hit[15] = 1'b1;
            9'h01B: hit[16] = 1'b1;
            9'h015: hit[17] = 1'b1;
            9'h01D: hit[18] = 1'b1;
            9'h01E: hit[19] = 1'b1;
            9'h006: hit[20] = 1'b1;
            9'h036: hit[21] = 1'b1;
            9'h02C: hit[22] = 1'b1;
            default: ;
        endcase
        kl_d = kl_q;
        if (key_ev) kl_d = (kl_q & ~hit) | (hit & {NK{ps2_key[9]}});
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            armed_q <= 1'b0;
            tog_q   <= 1'b0;
            kl_q    <= '0;
            test_q  <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            tog_q   <= ps2_key[10];
            kl_q    <= kl_d;
            test_q  <= kl_q[22];
        end
    end

    assign out_test = test_q;

`ifdef INPUT_AUTOFIRE_EN
    logic [19:0] af_cnt_q;
    logic        af_phase_q;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b1;
        end else if (af_cnt_q == AUTOFIRE_DIV - 20'd1) begin
            af_cnt_q   <= '0;
            af_phase_q <= ~af_phase_q;
        end else begin
            af_cnt_q   <= af_cnt_q + 20'd1;
        end
    end

    assign gate = ~autofire_en | {(BUTTONS*PLAYERS){af_phase_q}};
`else
    logic unused_af;
    assign unused_af = ^autofire_en;
    assign gate      = '1;
`endif

    logic unused_bits;
    assign unused_bits = ^{kl_q, joy_in};

    for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
        logic [15:0]        j;
        logic [3:0]         kdir;
        logic [BUTTONS-1:0] kbtn;
        logic               kstart, kcoin;

        assign j = joy_in[16*p +: 16];
        if (p == 0) begin : g_k0
            assign kdir   = kl_q[3:0];
            assign kbtn   = kl_q[4 +: BUTTONS];
            assign kstart = kl_q[8] | kl_q[9];
            assign kcoin  = kl_q[10];
        end else if (p == 1) begin : g_k1
            assign kdir   = kl_q[14:11];
            assign kbtn   = kl_q[15 +: BUTTONS];
            assign kstart = kl_q[19] | kl_q[20];
            assign kcoin  = kl_q[21];
        end else begin : g_kn
            assign kdir   = '0;
            assign kbtn   = '0;
            assign kstart = 1'b0;
            assign kcoin  = 1'b0;
        end

        arcade_player_ctl #(.BUTTONS(BUTTONS), .COIN_PULSE(COIN_PULSE)) u_pl (
            .clk_sys     (clk_sys),
            .rst         (RESET),
            .dir_i       (kdir | j[3:0]),
            .btn_i       (kbtn | j[4 +: BUTTONS]),
            .start_i     (kstart | j[4+BUTTONS]),
            .coin_i      (kcoin | j[5+BUTTONS]),
            .rotate_i    (rotate),
            .fire_gate_i (gate[BUTTONS*p +: BUTTONS]),
            .dir_o       (out_dir[4*p +: 4]),
            .btn_o       (out_btn[BUTTONS*p +: BUTTONS]),
            .start_o     (out_start[p]),
            .coin_o      (out_coin[p])
        );
    end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Directed bench for arcade_input_mapper: expectations are queued with a due cycle when
// stimulus is applied and checked when that cycle's registered outputs are visible.

module tb_arcade_input_mapper;
    localparam int PL = 3;
    localparam int BT = 2;

    logic             clk_sys = 1'b0;
    logic             RESET;
    logic [10:0]      ps2_key;
    logic [16*PL-1:0] joy_in;
    logic [1:0]       rotate;
    logic [4*PL-1:0]  out_dir;
    logic [BT*PL-1:0] out_btn;
    logic [PL-1:0]    out_start;
    logic [PL-1:0]    out_coin;
    logic             out_test;
    logic [BT*PL-1:0] autofire_en;

    arcade_input_mapper #(
        .PLAYERS(PL), .BUTTONS(BT), .COIN_PULSE(16'd4), .AUTOFIRE_DIV(20'd3)
    ) dut (
        .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key), .joy_in(joy_in),
        .rotate(rotate), .out_dir(out_dir), .out_btn(out_btn), .out_start(out_start),
        .out_coin(out_coin), .out_test(out_test), .autofire_en(autofire_en)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        string       tag;
        int          due;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic tgl = 1'b1;

    function automatic logic [31:0] obs(int sel);
        case (sel)
            0:       return 32'(out_dir);
            1:       return 32'(out_btn);
            2:       return 32'(out_start);
            3:       return 32'(out_coin);
            default: return 32'(out_test);
        endcase
    endfunction

    task automatic cmp(string tag, logic [31:0] o, logic [31:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, o, e);
        end
    endtask

    task automatic chk(string tag, int sel, logic [31:0] e);
        cmp(tag, obs(sel), e);
    endtask

    task automatic push(string tag, int sel, logic [31:0] v, int lat);
        exp_t x;
        x.tag = tag; x.due = cyc + lat; x.sel = sel; x.exp = v;
        sbq.push_back(x);
    endtask

    task automatic tick();
        exp_t keep[$];
        @(posedge clk_sys);
        #1;
        cyc++;
        foreach (sbq[i]) begin
            if (sbq[i].due == cyc) chk(sbq[i].tag, sbq[i].sel, sbq[i].exp);
            else keep.push_back(sbq[i]);
        end
        sbq = keep;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic key(logic pressed, logic [8:0] code);
        tgl = ~tgl;
        ps2_key = {tgl, pressed, code};
    endtask

    initial begin
        logic s[12];
        RESET = 1'b0; ps2_key = {1'b1, 1'b0, 9'h000}; joy_in = '0; rotate = 2'd0;
        autofire_en = '0;
        #2 RESET = 1'b1;
        ticks(2);
        chk("rst_dir", 0, 0); chk("rst_btn", 1, 0); chk("rst_start", 2, 0);
        chk("rst_coin", 3, 0); chk("rst_test", 4, 0);

        // release with toggle held high: arming edge decodes nothing
        RESET = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            push("arm_dir", 0, 0, k); push("arm_test", 4, 0, k);
        end
        ticks(3);

        key(1'b1, 9'h075); push("kU_lat1", 0, 0, 1); push("kU_lat2", 0, 12'h008, 2); tick();
        key(1'b1, 9'h175); push("kU_ext", 0, 12'h008, 1); push("kU_ext2", 0, 12'h008, 2); ticks(2);
        key(1'b0, 9'h075); push("kU_rel1", 0, 12'h008, 1); push("kU_rel2", 0, 0, 2); ticks(2);
        key(1'b1, 9'h12D); push("unmapped_e0", 0, 0, 2); ticks(2);
        key(1'b0, 9'h12D); ticks(2);

        joy_in[3:0] = 4'b1100; push("socd_ud", 0, 0, 1); tick();
        joy_in[3:0] = 4'b1000; push("socd_u", 0, 12'h008, 1); tick();
        joy_in[3:0] = 4'b0011; push("socd_lr", 0, 0, 1); tick();
        joy_in[3:0] = 4'b1010; push("diag_ul", 0, 12'h00A, 1); tick();
        joy_in[3:0] = 4'b0000; push("joy_clr", 0, 0, 1); tick();

        rotate = 2'd1; joy_in[19:16] = 4'b0010; push("rot_cw_l", 0, 12'h080, 1); tick();
        rotate = 2'd2; push("rot_ccw_l", 0, 12'h040, 1); tick();
        rotate = 2'd3; push("rot_3_l", 0, 12'h020, 1); tick();
        rotate = 2'd1; joy_in[19:16] = 4'b1000; push("rot_cw_u", 0, 12'h010, 1); tick();
        joy_in[19:16] = 4'b1100; push("rot_socd", 0, 0, 1); tick();
        rotate = 2'd0; joy_in[19:16] = 4'b0000; push("rot_clr", 0, 0, 1); tick();

        key(1'b1, 9'h02D); push("p1_kU", 0, 12'h080, 2); ticks(2);
        key(1'b0, 9'h02D); push("p1_kU_rel", 0, 0, 2); ticks(2);
        key(1'b1, 9'h02C); push("test_on", 4, 1, 2); ticks(2);
        key(1'b0, 9'h02C); push("test_off", 4, 0, 2); ticks(2);

        key(1'b1, 9'h01B); push("p1_btn1", 1, 6'b001000, 2); ticks(2);
        joy_in[36] = 1'b1; push("p2_btn0", 1, 6'b011000, 1); tick();
        key(1'b0, 9'h01B); joy_in[36] = 1'b0;
        push("btn_rel1", 1, 6'b001000, 1); push("btn_rel2", 1, 0, 2); ticks(2);

        key(1'b1, 9'h005); push("start_005", 2, 3'b001, 2); ticks(2);
        key(1'b1, 9'h016); tick();
        key(1'b0, 9'h005); push("start_016", 2, 3'b001, 2); ticks(2);
        key(1'b0, 9'h016); push("start_rel", 2, 0, 2); ticks(2);
        joy_in[38] = 1'b1; push("p2_start", 2, 3'b100, 1); tick();
        joy_in[38] = 1'b0; push("p2_start_rel", 2, 0, 1); tick();

        // coin: re-press and joystick coin inside the pulse, then a held WAIT, then re-press
        key(1'b1, 9'h02E);
        for (int k = 1; k <= 18; k++)
            push("coin0", 3, ((k >= 2 && k <= 5) || (k >= 14 && k <= 17)) ? 32'd1 : 32'd0, k);
        ticks(2);
        key(1'b0, 9'h02E); tick();
        key(1'b1, 9'h02E); tick();
        joy_in[7] = 1'b1; tick();
        joy_in[7] = 1'b0; ticks(5);
        key(1'b0, 9'h02E); ticks(2);
        key(1'b1, 9'h02E); ticks(6);
        key(1'b0, 9'h02E); push("coin0_end", 3, 0, 2); ticks(2);

        joy_in[39] = 1'b1;
        for (int k = 1; k <= 6; k++) push("coin2", 3, (k <= 4) ? 32'd4 : 32'd0, k);
        ticks(6);
        joy_in[39] = 1'b0; ticks(2);

        autofire_en = 6'b000001; joy_in[4] = 1'b1;
`ifdef INPUT_AUTOFIRE_EN
        tick();
        for (int k = 0; k < 12; k++) begin
            tick();
            s[k] = out_btn[0];
        end
        for (int k = 0; k < 9; k++) cmp("autofire_phase", 32'(s[k+3]), 32'(~s[k]));
`else
        for (int k = 1; k <= 12; k++) push("btn_noaf", 1, 6'b000001, k);
        ticks(12);
        s[0] = 1'b0;
`endif
        joy_in[4] = 1'b0; autofire_en = '0; push("btn_off", 1, 0, 1); tick();

        ticks(3);
        cmp("sb_drain", 32'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
